gpu_text_engine: RTL and testbench
==================================

Name: gpu_text_engine

Overview:
- Memory-mapped text-mode GPU peripheral on the 64-bit processor bus.
- Decodes its device-select byte in address[63:56] and exposes control, status and a parametrised COLS x ROWS character framebuffer.
- Contains a command engine that clears or scrolls the framebuffer autonomously.
- A second read port serves the VGA character generator.

Parameters:
- GPUAddress, 8'b00000010, device select compared against address[63:56].
- GPUControlAddress, 56'd0, control register offset.
- GPUStatusAddress, 56'd2, status register offset.
- GPUCharactersAddress, 56'd4, offset of character 0; character k lives at GPUCharactersAddress+k.
- COLS, 80, characters per row.
- ROWS, 30, rows; N = COLS*ROWS.
- CHAR_WIDTH, 8, bits per character cell.
- INDEX_WIDTH, 12, index width; must satisfy 2^INDEX_WIDTH >= N.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- resetN  in  1  synchronous, active-low reset.
- address  in  64  bus address.
- data  inout  64  bus data; driven only when readValid=1, otherwise high-Z.
- read  in  1  bus read strobe, one cycle per request.
- write  in  1  bus write strobe, one cycle per request.
- readValid  out  1  data carries read response this cycle.
- busy  out  1  command engine active.
- scanIndex  in  INDEX_WIDTH  display-side character index.
- scanChar  out  CHAR_WIDTH  character at scanIndex; 1-cycle latency; 0 when displayEnable=0 or scanIndex>=N.

Behaviour:
- Reset (resetN=0 at an edge): readValid=0, busy=0, scanChar=0, fill=0, displayEnable=0, cmdDropped=0, writeDropped=0, engine to IDLE. Framebuffer contents are not altered. A reset mid-command aborts the command; cells already written keep their new values.
- Select: sel = (address[63:56]==GPUAddress); off = address[55:0].
- Write, sel&write:
  - Control: data[1:0] cmd (01 CLEAR, 10 SCROLL, 00/11 none); data[2] displayEnable; data[8+CHAR_WIDTH-1:8] fill.
  - Control while busy: fill and displayEnable update, cmd is ignored, cmdDropped<=1.
  - Chars: index = off-GPUCharactersAddress; if index<N, cell<=data[CHAR_WIDTH-1:0], else ignored.
  - Char write while busy: dropped, writeDropped<=1.
- Read, sel&read&!write:
  - Response on the next cycle, readValid=1 for exactly one cycle.
  - Control returns {zeros, fill at [8+:CHAR_WIDTH], displayEnable at [2], 2'b00}.
  - Status returns {61'b0, writeDropped, cmdDropped, busy} sampled at the request cycle. cmdDropped and writeDropped clear on that read; a set event in the same cycle wins.
  - Chars return the zero-extended cell if index<N and !busy, else 0.
  - Unmapped offsets return 0.
- Read and write asserted together: write performed, no read response.
- Engine FSM states IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL; counter i.
  - CLEAR accepted at edge t: busy=1 from t+1. CLEAR writes fill to cell i for i=0..N-1, one per cycle (N cycles), then IDLE, busy=0 on cycle t+N+1.
  - SCROLL: for i=0..N-COLS-1, SCR_RD reads cell i+COLS, SCR_WR writes it to cell i (2 cycles per cell). Then SCR_FILL writes fill to cells N-COLS..N-1, one per cycle. Total busy = 2*(N-COLS)+COLS cycles.
  - ROWS=1: SCROLL degenerates to a fill of row 0.
  - Counter terminates exactly at N-1; no wrap past N.
- Scan port is independent of the bus and the engine and is never stalled. Reading a cell written in the same cycle returns old data.

Test Plan:
- Reset, then read status → readValid one cycle later, data=0; scanChar=0; data high-Z when readValid=0.
- displayEnable=1; write 8'h41 to char index 5 (address {8'h02,56'd9}); read back → 64'h41; scanIndex=5 → scanChar=8'h41 next cycle; write to index N → ignored, read returns 0.
- Control write {fill=8'h20, cmd=01}: busy high exactly N=2400 cycles; then every cell reads 8'h20.
- Preload row r with char r+1 for all rows; SCROLL with fill=8'h2E: busy 2*2320+80=4720 cycles; afterwards row r holds r+2 and row 29 holds 8'h2E.
- During CLEAR: char write and a second SCROLL command → both dropped; status reads 3'b111; the next status read after completion returns 0.
- Assert resetN=0 mid-SCROLL → busy=0 next cycle; engine idle; a new CLEAR is accepted immediately.

Source files
------------

// File: rtl/gpu_text_engine.sv
// Text-mode GPU peripheral: a memory-mapped COLS x ROWS character framebuffer with
// control/status registers, a clear/scroll command engine and a display scan port.
module gpu_text_engine #(
  parameter logic [7:0]  GPUAddress           = 8'b00000010,
  parameter logic [55:0] GPUControlAddress    = 56'd0,
  parameter logic [55:0] GPUStatusAddress     = 56'd2,
  parameter logic [55:0] GPUCharactersAddress = 56'd4,
  parameter int          COLS                 = 80,
  parameter int          ROWS                 = 30,
  parameter int          CHAR_WIDTH           = 8,
  parameter int          INDEX_WIDTH          = 12
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [63:0]            address,
  inout  wire  [63:0]            data,
  input  logic                   read,
  input  logic                   write,
  output logic                   readValid,
  output logic                   busy,
  input  logic [INDEX_WIDTH-1:0] scanIndex,
  output logic [CHAR_WIDTH-1:0]  scanChar
);

  localparam int N     = COLS * ROWS;
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] N_IDX      = INDEX_WIDTH'(N);
  localparam logic [INDEX_WIDTH-1:0] LAST       = INDEX_WIDTH'(N - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_SHIFT = INDEX_WIDTH'((ROWS > 1) ? (N - COLS - 1) : 0);
  localparam logic [INDEX_WIDTH-1:0] FILL_START = INDEX_WIDTH'(N - COLS);
  localparam logic [INDEX_WIDTH-1:0] COLS_IDX   = INDEX_WIDTH'(COLS);

  typedef enum logic [2:0] {IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL} state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [CHAR_WIDTH-1:0]   fill_reg;
  logic                    display_enable_reg;
  logic                    cmd_dropped_reg;
  logic                    write_dropped_reg;
  logic                    read_valid_reg;
  logic                    resp_is_char_reg;
  logic [63:0]             resp_word_reg;
  logic                    scan_valid_reg;

  logic [CHAR_WIDTH-1:0]   mem [DEPTH];
  logic [CHAR_WIDTH-1:0]   bus_rd_q, eng_rd_q, scan_rd_q;

  // Bus decode
  logic                    sel, bus_wr, bus_rd, ctrl_wr, stat_rd, ctrl_rd, char_hit;
  logic [55:0]             off, char_off;
  logic [INDEX_WIDTH-1:0]  char_idx;
  logic [1:0]              cmd;

  assign sel      = (address[63:56] == GPUAddress);
  assign off      = address[55:0];
  assign char_off = off - GPUCharactersAddress;
  assign char_hit = (off >= GPUCharactersAddress) && (char_off < 56'(N));
  assign char_idx = char_off[INDEX_WIDTH-1:0];
  assign bus_wr   = sel && write;
  assign bus_rd   = sel && read && !write;
  assign ctrl_wr  = bus_wr && (off == GPUControlAddress);
  assign ctrl_rd  = bus_rd && (off == GPUControlAddress);
  assign stat_rd  = bus_rd && (off == GPUStatusAddress);
  assign cmd      = data[1:0];
  assign busy     = (state_reg != IDLE);

  wire unused_bits = ^{data[63:8+CHAR_WIDTH], data[7:3], char_off[55:INDEX_WIDTH]};

  // Engine next-state logic; the single write port belongs to the engine while busy
  logic                  eng_we;
  logic [CHAR_WIDTH-1:0] eng_wdata;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    eng_we     = 1'b0;
    eng_wdata  = fill_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_wr && cmd == 2'b01) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (ctrl_wr && cmd == 2'b10) begin
          if (ROWS == 1) begin
            state_next = SCR_FILL;
            cnt_next   = FILL_START;
          end else begin
            state_next = SCR_RD;
            cnt_next   = '0;
          end
        end
      end
      CLEAR, SCR_FILL: begin
        eng_we = 1'b1;
        if (cnt_reg == LAST) state_next = IDLE;
        else cnt_next = cnt_reg + 1'b1;
      end
      SCR_RD: state_next = SCR_WR;
      SCR_WR: begin
        eng_we    = 1'b1;
        eng_wdata = eng_rd_q;
        if (cnt_reg == LAST_SHIFT) begin
          state_next = SCR_FILL;
          cnt_next   = FILL_START;
        end else begin
          state_next = SCR_RD;
          cnt_next   = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  logic [CHAR_WIDTH-1:0]  mem_wdata;

  assign mem_we    = busy ? eng_we : (bus_wr && char_hit);
  assign mem_waddr = busy ? cnt_reg : char_idx;
  assign mem_wdata = busy ? eng_wdata : data[CHAR_WIDTH-1:0];

  // Framebuffer: one write port, three registered read ports, never reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    bus_rd_q  <= mem[char_idx];
    eng_rd_q  <= mem[cnt_reg + COLS_IDX];
    scan_rd_q <= mem[scanIndex];
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      fill_reg           <= '0;
      display_enable_reg <= 1'b0;
      cmd_dropped_reg    <= 1'b0;
      write_dropped_reg  <= 1'b0;
      read_valid_reg     <= 1'b0;
      resp_is_char_reg   <= 1'b0;
      resp_word_reg      <= '0;
      scan_valid_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (ctrl_wr) begin
        fill_reg           <= data[8 +: CHAR_WIDTH];
        display_enable_reg <= data[2];
      end
      // Clear-on-read first so a same-cycle set event takes priority
      if (stat_rd) begin
        cmd_dropped_reg   <= 1'b0;
        write_dropped_reg <= 1'b0;
      end
      if (ctrl_wr && busy) cmd_dropped_reg <= 1'b1;
      if (bus_wr && char_hit && busy) write_dropped_reg <= 1'b1;

      read_valid_reg   <= bus_rd;
      resp_is_char_reg <= bus_rd && char_hit && !busy;
      if (stat_rd)
        resp_word_reg <= {61'b0, write_dropped_reg, cmd_dropped_reg, busy};
      else if (ctrl_rd)
        resp_word_reg <= {{(56-CHAR_WIDTH){1'b0}}, fill_reg, 5'b0, display_enable_reg, 2'b00};
      else
        resp_word_reg <= '0;
      scan_valid_reg <= display_enable_reg && (scanIndex < N_IDX);
    end
  end

  assign readValid = read_valid_reg;
  assign data      = read_valid_reg ?
                     (resp_is_char_reg ? {{(64-CHAR_WIDTH){1'b0}}, bus_rd_q} : resp_word_reg) :
                     64'bz;
  assign scanChar  = scan_valid_reg ? scan_rd_q : '0;

endmodule

// File: tb/tb_gpu_text_engine.sv
// Scoreboard bench for gpu_text_engine: bus reads and scan reads are compared
// against expectations queued when each request is issued.
module tb_gpu_text_engine;
  localparam int N    = 2400;
  localparam int COLS = 80;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [63:0] address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [63:0] data_drv = '0;
  logic        data_oe = 1'b0;
  wire  [63:0] data;
  logic        readValid, busy;
  logic [11:0] scanIndex = '0;
  logic [7:0]  scanChar;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  scan_q[$];
  logic [7:0]  exp_fb [N];

  assign data = data_oe ? data_drv : 64'bz;

  gpu_text_engine dut (
    .clock(clock), .resetN(resetN), .address(address), .data(data),
    .read(read), .write(write), .readValid(readValid), .busy(busy),
    .scanIndex(scanIndex), .scanChar(scanChar)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [55:0] off, input logic [63:0] val, input bit quiet = 0);
    address  = {8'h02, off};
    write    = 1'b1;
    data_drv = val;
    data_oe  = 1'b1;
    cyc();
    write   = 1'b0;
    data_oe = 1'b0;
    if (!quiet) $display("WR off=%0d data=%h", off, val);
  endtask

  // Issues one read; ok is set when readValid is high for exactly the response cycle.
  task automatic bus_read(input logic [55:0] off, output logic [63:0] got, output bit ok);
    logic rv1;
    address = {8'h02, off};
    read    = 1'b1;
    cyc();
    read = 1'b0;
    rv1  = readValid;
    got  = data;
    cyc();
    ok = (rv1 === 1'b1) && (readValid === 1'b0);
    $display("RD off=%0d data=%h valid=%0b", off, got, rv1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      cyc();
    end
  endtask

  task automatic read_expect(input logic [55:0] off, input logic [63:0] expv, input string name);
    logic [63:0] got, e;
    bit ok;
    exp_q.push_back(expv);
    bus_read(off, got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL %s: got %h (valid_ok=%0b) expected %h", name, got, ok, e);
    end
  endtask

  task automatic scan_sweep(input string name);
    logic [7:0] g, e;
    for (int i = 0; i < N; i++) begin
      scan_q.push_back(exp_fb[i]);
      scanIndex = 12'(i);
      cyc();
      g = scanChar;
      e = scan_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, g, e);
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) cyc();
    checks++;
    if (readValid !== 1'b0 || busy !== 1'b0 || scanChar !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b busy=%b scan=%h expected 0 0 00", readValid, busy, scanChar);
    end
    resetN = 1'b1;
    cyc();
    read_expect(56'd2, 64'h0, "reset_status");
    read_expect(56'd0, 64'h0, "reset_control");
  endtask

  task automatic test_chars();
    logic [7:0] g;
    bus_write(56'd0, 64'h4);
    bus_write(56'd9, 64'h41);
    read_expect(56'd9, 64'h41, "char5_read");
    scan_q.push_back(8'h41);
    scanIndex = 12'd5;
    cyc();
    g = scanChar;
    checks++;
    if (g !== scan_q[0]) begin
      errors++;
      $display("FAIL scan_char5: got %h expected %h", g, scan_q[0]);
    end
    void'(scan_q.pop_front());
    bus_write(56'(4 + N), 64'h99);
    read_expect(56'(4 + N), 64'h0, "char_N_read");
    scanIndex = 12'(N);
    cyc();
    checks++;
    if (scanChar !== 8'h00) begin
      errors++;
      $display("FAIL scan_out_of_range: got %h expected 00", scanChar);
    end
    read_expect(56'd1, 64'h0, "unmapped_read");
    read_expect(56'd0, 64'h4, "control_read");
    address = {8'h03, 56'd9};
    read    = 1'b1;
    cyc();
    read = 1'b0;
    checks++;
    if (readValid !== 1'b0) begin
      errors++;
      $display("FAIL wrong_select: got readValid=%b expected 0", readValid);
    end
    cyc();
  endtask

  task automatic test_rw_collision();
    address  = {8'h02, 56'd10};
    read     = 1'b1;
    write    = 1'b1;
    data_drv = 64'h42;
    data_oe  = 1'b1;
    cyc();
    read = 1'b0; write = 1'b0; data_oe = 1'b0;
    $display("RW off=10 data=42");
    checks++;
    if (readValid !== 1'b0) begin
      errors++;
      $display("FAIL rw_no_response: got readValid=%b expected 0", readValid);
    end
    cyc();
    read_expect(56'd10, 64'h42, "rw_write_done");
  endtask

  task automatic test_clear();
    int n;
    bus_write(56'd0, 64'h2005);
    wait_idle(n);
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL clear_busy_cycles: got %0d expected %0d", n, N);
    end
    for (int i = 0; i < N; i++) exp_fb[i] = 8'h20;
    scan_sweep("clear_cell");
    read_expect(56'd4, 64'h20, "clear_first");
    read_expect(56'(4 + N - 1), 64'h20, "clear_last");
  endtask

  task automatic test_scroll();
    int n;
    for (int r = 0; r < N / COLS; r++)
      for (int c = 0; c < COLS; c++) begin
        bus_write(56'(4 + r * COLS + c), 64'(r + 1), 1'b1);
        exp_fb[r * COLS + c] = 8'(r + 1);
      end
    $display("WR preload rows 0..29 with row+1");
    bus_write(56'd0, 64'h2E06);
    wait_idle(n);
    checks++;
    if (n != 2 * (N - COLS) + COLS) begin
      errors++;
      $display("FAIL scroll_busy_cycles: got %0d expected %0d", n, 2 * (N - COLS) + COLS);
    end
    for (int i = 0; i < N - COLS; i++) exp_fb[i] = exp_fb[i + COLS];
    for (int i = N - COLS; i < N; i++) exp_fb[i] = 8'h2E;
    scan_sweep("scroll_cell");
    read_expect(56'd4, 64'h02, "scroll_row0");
    read_expect(56'(4 + N - 1), 64'h2E, "scroll_row29");
  endtask

  task automatic test_drop();
    int n;
    bus_write(56'd0, 64'h5505);
    bus_write(56'd4, 64'hAA);
    bus_write(56'd0, 64'h5506);
    read_expect(56'd2, 64'h7, "drop_status");
    wait_idle(n);
    checks++;
    if (n != N - 4) begin
      errors++;
      $display("FAIL drop_busy_remaining: got %0d expected %0d", n, N - 4);
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_scroll_ignored: got busy=%b expected 0", busy);
    end
    read_expect(56'd2, 64'h0, "drop_status_cleared");
    read_expect(56'd4, 64'h55, "drop_cell0");
    read_expect(56'd0, 64'h5504, "drop_control");
  endtask

  task automatic test_reset_mid();
    int n;
    bus_write(56'd0, 64'h2E06);
    repeat (100) cyc();
    resetN = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || readValid !== 1'b0 || scanChar !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b rv=%b scan=%h expected 0 0 00", busy, readValid, scanChar);
    end
    resetN = 1'b1;
    read_expect(56'd2, 64'h0, "midreset_status");
    read_expect(56'd0, 64'h0, "midreset_control");
    bus_write(56'd0, 64'h0001);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear_accept: got busy=%b expected 1", busy);
    end
    wait_idle(n);
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL midreset_clear_cycles: got %0d expected %0d", n, N);
    end
    read_expect(56'd4, 64'h0, "midreset_cell0");
    read_expect(56'(4 + 1234), 64'h0, "midreset_cell1234");
  endtask

  initial begin
    test_reset();
    test_chars();
    test_rw_collision();
    test_clear();
    test_scroll();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
